// File: rtl/mreq_arb_if.sv
// rtl/mreq_arb_if.sv - requester and downstream handshake bundle for mreq_arb
interface mreq_arb_if #(
   parameter int NREQ   = 4,
   parameter int MREQ_W = 44
);
   localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        i_req_valid;
   logic [NREQ-1:0]        o_req_ready;
   logic [NREQ*MREQ_W-1:0] i_req_mreq;
   logic [NREQ-1:0]        i_req_lock;
   logic                   o_mreq_valid;
   logic                   i_mreq_ready;
   logic [MREQ_W-1:0]      o_mreq;
   logic [GID_W-1:0]       o_grant_id;
   logic                   o_busy;

   modport slave (
      input  i_req_valid, i_req_mreq, i_req_lock, i_mreq_ready,
      output o_req_ready, o_mreq_valid, o_mreq, o_grant_id, o_busy
   );

   modport master (
      output i_req_valid, i_req_mreq, i_req_lock, i_mreq_ready,
      input  o_req_ready, o_mreq_valid, o_mreq, o_grant_id, o_busy
   );
endinterface

// File: rtl/mreq_arb.sv
// rtl/mreq_arb.sv - round-robin memory-request arbiter with lockable grants
// and a single registered output slot.
module mreq_arb #(
   parameter int NREQ     = 4,
   parameter int MREQ_W   = 44,
   parameter int LOCK_MAX = 16
) (
   input logic        i_clk,
   input logic        i_rst,
   mreq_arb_if.slave  bus
);
   localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [GID_W-1:0]    r_ptr;
   logic [GID_W-1:0]    r_gid;
   logic [7:0]          r_lcnt;
   logic [MREQ_W-1:0]   r_mreq;

   logic                w_found;
   logic [GID_W-1:0]    w_sel;
   logic [NREQ-1:0]     w_hot;
   logic [MREQ_W-1:0]   w_mreq;
   logic                w_lock;
   logic [NREQ-1:0]     w_ready;
   logic                w_accept;
   logic [7:0]          w_base;
   logic                w_keep;
   logic [GID_W-1:0]    w_ptr_nx;
   logic [7:0]          w_lcnt_nx;

   // Lowest (k - ptr) mod NREQ among valid requesters wins.
   always_comb begin : sel_blk
      int best;
      int cost;
      best    = NREQ;
      cost    = 0;
      w_found = 1'b0;
      w_sel   = '0;
      w_hot   = '0;
      w_mreq  = '0;
      w_lock  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cost = (k >= int'(r_ptr)) ? (k - int'(r_ptr)) : (k + NREQ - int'(r_ptr));
         if (bus.i_req_valid[k] && (cost < best)) begin
            best     = cost;
            w_found  = 1'b1;
            w_sel    = GID_W'(k);
            w_hot    = '0;
            w_hot[k] = 1'b1;
            w_mreq   = bus.i_req_mreq[k*MREQ_W +: MREQ_W];
            w_lock   = bus.i_req_lock[k];
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ready    = '0;
      w_accept   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_accept   = 1'b1;
               w_state_nx = S_HOLD;
               if (!i_rst) begin
                  w_ready = w_hot;
               end
            end
         end
         S_HOLD: begin
            if (bus.i_mreq_ready) begin
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // A nonzero count belongs to the requester ptr points at; anyone else starts fresh.
   always_comb begin
      w_base    = ((r_lcnt != 8'd0) && (w_sel == r_ptr)) ? r_lcnt : 8'd0;
      w_keep    = w_lock && ((9'(w_base) + 9'd1) < 9'(LOCK_MAX));
      w_ptr_nx  = w_sel;
      w_lcnt_nx = 8'd0;
      if (w_keep) begin
         w_ptr_nx  = w_sel;
         w_lcnt_nx = w_base + 8'd1;
      end else begin
         w_ptr_nx  = (int'(w_sel) == NREQ - 1) ? '0 : (w_sel + GID_W'(1));
         w_lcnt_nx = 8'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_lcnt  <= '0;
         r_mreq  <= '0;
         r_gid   <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_mreq <= w_mreq;
            r_gid  <= w_sel;
            r_ptr  <= w_ptr_nx;
            r_lcnt <= w_lcnt_nx;
         end
      end
   end

   assign bus.o_req_ready  = w_ready;
   assign bus.o_mreq_valid = (r_state == S_HOLD);
   assign bus.o_busy       = (r_state == S_HOLD);
   assign bus.o_mreq       = r_mreq;
   assign bus.o_grant_id   = r_gid;
endmodule

// File: tb/tb_mreq_arb.sv
// tb/tb_mreq_arb.sv - scoreboard bench for mreq_arb: directed scenarios plus
// randomized traffic against a cycle-level round-robin/lock reference model.
module tb_mreq_arb;
   localparam int N   = 4;
   localparam int W   = 44;
   localparam int LMX = 3;

   typedef struct {
      int          id;
      logic [W-1:0] mreq;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] v, l, refill;
   logic [W-1:0] m [N];
   logic         rdy;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;

   exp_t         exp_q [$];
   int           log_id [$];
   logic [W-1:0] log_mreq [$];
   int           acc_cyc [$];
   logic [N-1:0] acc_n;

   int m_ptr = 0, m_owner = -1, m_streak = 0;
   bit m_hold = 0;

   mreq_arb_if #(.NREQ(N), .MREQ_W(W)) bus ();

   mreq_arb #(.NREQ(N), .MREQ_W(W), .LOCK_MAX(LMX)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   assign bus.i_req_valid  = v;
   assign bus.i_req_lock   = l;
   assign bus.i_req_mreq   = {m[3], m[2], m[1], m[0]};
   assign bus.i_mreq_ready = rdy;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tot++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
   endtask

   function automatic logic [W-1:0] rand_mreq();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // Reference model: predicts each cycle which requester is accepted.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int sel, k, base;
      exp_t e;
      cyc++;
      acc_n   = bus.o_req_ready & v;
      exp_rdy = '0;
      if (rst) begin
         check("ready_in_reset", bus.o_req_ready, '0);
         check("valid_in_reset", bus.o_mreq_valid, 1'b0);
         m_hold = 0; m_ptr = 0; m_owner = -1; m_streak = 0;
         exp_q.delete();
      end else begin
         check("busy", bus.o_busy, m_hold);
         check("mreq_valid", bus.o_mreq_valid, m_hold);
         if (!m_hold) begin
            sel = -1;
            for (int c = 0; c < N; c++) begin
               k = (m_ptr + c) % N;
               if (sel < 0 && v[k]) sel = k;
            end
            if (sel >= 0) begin
               exp_rdy[sel] = 1'b1;
               e.id = sel; e.mreq = m[sel];
               exp_q.push_back(e);
               acc_cyc.push_back(cyc);
               base = (sel == m_owner) ? m_streak : 0;
               if (l[sel] && (base + 1 < LMX)) begin
                  m_owner = sel; m_streak = base + 1; m_ptr = sel;
               end else begin
                  m_owner = -1; m_streak = 0; m_ptr = (sel + 1) % N;
               end
               m_hold = 1;
            end
         end else if (rdy) begin
            m_hold = 0;
         end
         check("req_ready", bus.o_req_ready, exp_rdy);
      end
   end

   // Monitor: every downstream handshake must match the oldest predicted grant.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.o_mreq_valid && rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_grant", bus.o_grant_id, 64'hFFFF);
         end else begin
            e = exp_q.pop_front();
            check("grant_id", bus.o_grant_id, e.id);
            check("mreq", bus.o_mreq, e.mreq);
         end
         log_id.push_back(int'(bus.o_grant_id));
         log_mreq.push_back(bus.o_mreq);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (acc_n[k]) begin
            if (refill[k]) m[k] = rand_mreq();
            else v[k] = 1'b0;
         end
      end
   endtask

   task automatic wait_log(input int n, input int budget);
      int b = 0;
      while (log_id.size() < n && b < budget) begin
         step();
         b++;
      end
      if (log_id.size() < n) check("timeout_grants", log_id.size(), n);
   endtask

   task automatic wait_valid(input int budget);
      int b = 0;
      while (!bus.o_mreq_valid && b < budget) begin
         step();
         b++;
      end
      if (!bus.o_mreq_valid) check("timeout_valid", bus.o_mreq_valid, 1'b1);
   endtask

   task automatic do_reset();
      v = '0; l = '0; refill = '0; rdy = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      log_id.delete(); log_mreq.delete(); acc_cyc.delete();
   endtask

   initial begin
      int fair [6]  = '{0, 1, 2, 3, 0, 1};
      int lockx [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      int idlo [4]  = '{3, 3, 3, 0};
      logic [W-1:0] single, held;
      rst = 1'b1; v = '1; l = '0; refill = '0; rdy = 1'b0;
      for (int k = 0; k < N; k++) m[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mreq", bus.o_mreq, '0);
      check("rst_gid", bus.o_grant_id, '0);
      check("rst_valid", bus.o_mreq_valid, 1'b0);
      check("rst_busy", bus.o_busy, 1'b0);
      check("rst_ready", bus.o_req_ready, '0);

      // Single request
      do_reset();
      single = {1'b0, 1'b1, 2'd1, 8'd5, 32'h12345678};
      m[1] = single; rdy = 1'b1; v = 4'b0010;
      wait_log(1, 20);
      if (log_id.size() >= 1) begin
         check("single_id", log_id[0], 1);
         check("single_mreq", log_mreq[0], single);
      end
      step(); step();

      // Fair rotation
      do_reset();
      for (int k = 0; k < N; k++) m[k] = rand_mreq();
      refill = '1; v = '1; rdy = 1'b1;
      wait_log(6, 40);
      for (int i = 0; i < 6; i++)
         if (log_id.size() > i) check("fair_order", log_id[i], fair[i]);
      for (int i = 0; i < 5; i++)
         if (acc_cyc.size() > i + 1) check("fair_spacing", acc_cyc[i+1] - acc_cyc[i], 2);

      // Backpressure
      do_reset();
      m[2] = rand_mreq(); held = m[2]; v = 4'b0100; rdy = 1'b0;
      wait_valid(10);
      m[0] = rand_mreq(); v[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check("bp_mreq", bus.o_mreq, held);
         check("bp_gid", bus.o_grant_id, 2);
         check("bp_ready", bus.o_req_ready, '0);
      end
      rdy = 1'b1;
      wait_log(2, 20);
      if (log_id.size() >= 2) begin
         check("bp_first", log_id[0], 2);
         check("bp_second", log_id[1], 0);
      end

      // Lock limit
      do_reset();
      for (int k = 0; k < N; k++) m[k] = rand_mreq();
      l = 4'b0001; refill = 4'b0011; v = 4'b0011; rdy = 1'b1;
      wait_log(8, 60);
      for (int i = 0; i < 8; i++)
         if (log_id.size() > i) check("lock_order", log_id[i], lockx[i]);

      // Lock with idle owner, then a fresh lock streak
      do_reset();
      m[3] = rand_mreq(); l = 4'b1000; v = 4'b1000; rdy = 1'b1;
      wait_log(1, 20);
      m[0] = rand_mreq(); v[0] = 1'b1;
      wait_log(2, 20);
      if (log_id.size() >= 2) check("idle_owner", log_id[1], 0);
      m[0] = rand_mreq(); m[3] = rand_mreq();
      refill = 4'b1001; v = 4'b1001;
      wait_log(6, 40);
      for (int i = 0; i < 4; i++)
         if (log_id.size() > i + 2) check("relock_order", log_id[i+2], idlo[i]);

      // Reset mid-HOLD
      do_reset();
      m[1] = rand_mreq(); v = 4'b0010; rdy = 1'b0;
      wait_valid(10);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", bus.o_mreq_valid, 1'b0);
      check("arst_busy", bus.o_busy, 1'b0);
      check("arst_mreq", bus.o_mreq, '0);
      check("arst_ready", bus.o_req_ready, '0);
      step();
      for (int k = 0; k < N; k++) m[k] = rand_mreq();
      v = '1; rdy = 1'b1;
      step();
      rst = 1'b0;
      log_id.delete(); log_mreq.delete();
      wait_log(1, 20);
      if (log_id.size() >= 1) check("arst_first", log_id[0], 0);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step();
         rdy = ($urandom % 4) != 0;
         for (int k = 0; k < N; k++) begin
            if (!v[k] && ($urandom % 3 == 0)) begin
               m[k] = rand_mreq();
               l[k] = ($urandom % 3 == 0);
               v[k] = 1'b1;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
